// File: rtl/sum_display_scan.sv
// sum_display_scan: time-multiplexed driver for a 4-digit common-anode
// seven-segment display. It shows operand A, operand B, a dash and the sum.
// The operands and the sum are latched only at frame boundaries, so one scan
// frame never mixes old and new values.
//
// Ports:
//   clk    - system clock
//   reset  - asynchronous, active-high reset
//   a, b   - 2-bit operands from the switches
//   sum    - 3-bit adder result {carry, sum}
//   hold   - 1 = keep the current snapshot at the frame boundary
//   an     - digit anodes, active-low, an[3] is the leftmost digit
//   seg    - segments {g,f,e,d,c,b,a}, active-low
//   dp     - decimal point, active-low, always off
module sum_display_scan #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic [2:0] sum,
  input  logic       hold,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  typedef enum logic [1:0] {
    DIG_S    = 2'd0,
    DIG_DASH = 2'd1,
    DIG_B    = 2'd2,
    DIG_A    = 2'd3
  } digit_e;

  logic [CW-1:0] cnt_q, cnt_d;
  digit_e        state_q, state_d;
  logic [1:0]    snap_a_q, snap_a_d;
  logic [1:0]    snap_b_q, snap_b_d;
  logic [2:0]    snap_s_q, snap_s_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          last_tick;

  function automatic logic [6:0] decode(input logic [2:0] v);
    logic [6:0] r;
    case (v)
      3'd0:    r = 7'b1000000;
      3'd1:    r = 7'b1111001;
      3'd2:    r = 7'b0100100;
      3'd3:    r = 7'b0110000;
      3'd4:    r = 7'b0011001;
      3'd5:    r = 7'b0010010;
      3'd6:    r = 7'b0000010;
      default: r = 7'b1111000;
    endcase
    return r;
  endfunction

  assign last_tick = (cnt_q == CNT_LAST);

  // Refresh counter
  always_comb begin
    cnt_d = last_tick ? '0 : cnt_q + CW'(1);
  end

  // Snapshot: reload only when the last digit of a frame finishes
  always_comb begin
    snap_a_d = snap_a_q;
    snap_b_d = snap_b_q;
    snap_s_d = snap_s_q;
    if (last_tick && (state_q == DIG_A) && !hold) begin
      snap_a_d = a;
      snap_b_d = b;
      snap_s_d = sum;
    end
  end

  // Digit-select FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= DIG_S;
      cnt_q    <= '0;
      snap_a_q <= '0;
      snap_b_q <= '0;
      snap_s_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      snap_a_q <= snap_a_d;
      snap_b_q <= snap_b_d;
      snap_s_q <= snap_s_d;
    end
  end

  // Digit-select FSM: next state
  always_comb begin
    state_d = state_q;
    if (last_tick) begin
      case (state_q)
        DIG_S:    state_d = DIG_DASH;
        DIG_DASH: state_d = DIG_B;
        DIG_B:    state_d = DIG_A;
        default:  state_d = DIG_S;
      endcase
    end
  end

  // Digit-select FSM: outputs (registered below, so they lag the state by one cycle)
  always_comb begin
    an_d  = 4'b1111;
    seg_d = SEG_OFF;
    case (state_q)
      DIG_S: begin
        an_d  = 4'b1110;
        seg_d = decode(snap_s_q);
      end
      DIG_DASH: begin
        an_d  = 4'b1101;
        seg_d = SEG_DASH;
      end
      DIG_B: begin
        an_d  = 4'b1011;
        seg_d = decode({1'b0, snap_b_q});
      end
      default: begin
        an_d  = 4'b0111;
        seg_d = decode({1'b0, snap_a_q});
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_q  <= '1;
      seg_q <= '1;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_sum_display_scan.sv
// Randomized scoreboard bench for sum_display_scan (REFRESH_DIV = 4).
// The reference model derives each expected output from the edge count
// since reset release: digit = ((edge-1)/DIV) mod 4, and the snapshot is
// taken on every edge that is a multiple of 4*DIV unless hold is high.
module tb_sum_display_scan;

  localparam int DIV = 4;
  localparam int FRAME = 4 * DIV;

  logic       clk;
  logic       reset;
  logic [1:0] a, b;
  logic [2:0] sum;
  logic       hold;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  sum_display_scan #(.REFRESH_DIV(DIV)) dut (
    .clk  (clk),
    .reset(reset),
    .a    (a),
    .b    (b),
    .sum  (sum),
    .hold (hold),
    .an   (an),
    .seg  (seg),
    .dp   (dp)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   e;
  bit   done = 0;
  bit   directed;
  logic [1:0] ma, mb;
  logic [2:0] ms;
  logic [6:0] dec [8] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of stimulus and push the expected response for the next edge
  task automatic step();
    int   idx;
    exp_t x;
    if (!directed) begin
      if ($urandom_range(2) == 0) a = 2'($urandom_range(3));
      if ($urandom_range(2) == 0) b = 2'($urandom_range(3));
      if ($urandom_range(2) == 0) sum = 3'($urandom_range(7));
      if ($urandom_range(19) == 0) hold = ~hold;
    end
    e++;
    idx = ((e - 1) / DIV) % 4;
    x.an = ~(4'b0001 << idx);
    case (idx)
      0: x.seg = dec[ms];
      1: x.seg = 7'b0111111;
      2: x.seg = dec[{1'b0, mb}];
      default: x.seg = dec[{1'b0, ma}];
    endcase
    q.push_back(x);
    if ((e % FRAME) == 0 && !hold) begin
      ma = a;
      mb = b;
      ms = sum;
    end
  endtask

  task automatic release_reset();
    reset = 0;
    e = 0;
    ma = 0;
    mb = 0;
    ms = 0;
    step();
  endtask

  // Monitor: compare every registered output against the scoreboard
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && !done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL underflow at %0t: got no expected entry, required one", $time);
        end else begin
          x = q.pop_front();
          chk("an", int'(an), int'(x.an));
          chk("seg", int'(seg), int'(x.seg));
          chk("dp", int'(dp), 1);
          chk("one_anode", $countones(~an), 1);
        end
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1;
    a = 0;
    b = 0;
    sum = 0;
    hold = 0;
    directed = 1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_an", int'(an), 4'hF);
      chk("rst_seg", int'(seg), 7'h7F);
      chk("rst_dp", int'(dp), 1);
    end
    // Fixed operands for the first frames, then change them mid-frame
    a = 2'd2;
    b = 2'd3;
    sum = 3'd5;
    release_reset();
    repeat (2 * FRAME + DIV) begin
      @(negedge clk);
      step();
    end
    a = 2'd1;
    repeat (FRAME) begin
      @(negedge clk);
      step();
    end
    a = 2'd3;
    sum = 3'd7;
    repeat (2 * FRAME) begin
      @(negedge clk);
      step();
    end
    // Hold across several frames while the inputs change, then drop it mid-frame
    hold = 1;
    a = 0;
    b = 0;
    sum = 0;
    repeat (3 * FRAME + 5) begin
      @(negedge clk);
      step();
    end
    hold = 0;
    repeat (2 * FRAME) begin
      @(negedge clk);
      step();
    end
    directed = 0;
    repeat (400) begin
      @(negedge clk);
      step();
    end
    // Reset mid-scan at digit 2, count 2: outputs must go dark without a clock edge
    while ((e % FRAME) != 2 * DIV + 2) begin
      @(negedge clk);
      step();
    end
    @(posedge clk);
    #2;
    reset = 1;
    #1;
    chk("async_an", int'(an), 4'hF);
    chk("async_seg", int'(seg), 7'h7F);
    chk("async_dp", int'(dp), 1);
    q.delete();
    @(negedge clk);
    @(negedge clk);
    chk("held_rst_an", int'(an), 4'hF);
    release_reset();
    repeat (300) begin
      @(negedge clk);
      step();
    end
    @(posedge clk);
    #3;
    done = 1;
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sum_display_scan.md
Name: sum_display_scan

Overview:
- Downstream stage of the switch-driven adder datapath. Shows the 2-bit operands and the 3-bit adder sum on the 4-digit common-anode seven-segment display.
- Sequential, time-multiplexed scanner:
  - a refresh divider steps through the four digits;
  - a frame-boundary snapshot register stops tearing when switches change mid-scan;
  - a hold input freezes the displayed values.

Parameters:
- REFRESH_DIV, 100000: clk cycles each digit stays lit (1 ms at 100 MHz). Legal range is 2 or more.

Ports:
- clk  input  1  system clock, 100 MHz
- reset  input  1  asynchronous, active-high reset
- a  input  2  operand A, driven from the switches
- b  input  2  operand B, driven from the switches
- sum  input  3  adder result, {carry, sum bits}; value range 0..7
- hold  input  1  1 = freeze the snapshot; the display keeps its last values
- an  output  4  digit anodes, active-low; an[3] is the leftmost digit
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low; always 1 (off)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high. All flops are cleared immediately when reset rises, independent of clk.
- Reset values:
  - cnt = 0, idx = 0, snapshot {A,B,S} = 0
  - an = 4'b1111 (all digits dark), seg = 7'b1111111, dp = 1
- Refresh counter (cnt), width ceil(log2(REFRESH_DIV)):
  - If cnt == REFRESH_DIV-1: cnt <= 0 and idx <= idx+1, with idx wrapping 3 -> 0.
  - Otherwise: cnt <= cnt+1.
- Digit-select state machine (idx), four states, idx 0 -> 1 -> 2 -> 3 -> 0. Each state lasts exactly REFRESH_DIV cycles.
  - idx 0: an=1110, shows S (decoded 0..7)
  - idx 1: an=1101, shows a dash (seg=0111111)
  - idx 2: an=1011, shows B (decoded 0..3)
  - idx 3: an=0111, shows A (decoded 0..3)
- Output registers: an and seg are registered from the current idx and the snapshot. They update on every clk edge, so they lag idx by 1 cycle.
  - The first edge after reset deasserts gives an=1110, seg=1000000.
  - There is never more than one anode low, and no cycle has two anodes low.
- Snapshot:
  - Loads {a,b,sum} on the edge where cnt == REFRESH_DIV-1 AND idx == 3 AND hold == 0.
  - New values are therefore first visible on digit 0 of the next frame. A frame never mixes old and new values.
  - If hold == 1 at that edge, the snapshot keeps its value. Releasing hold takes effect at the next frame boundary, not immediately.
  - Inputs are otherwise ignored mid-frame.
- Decode table (active-low gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
- Width rules: A and B are zero-extended to 3 bits before decoding. Sum 7 is legal and decoded, even though the 2+2-bit adder tops out at 6.
- Reset mid-scan: outputs go dark immediately (asynchronous). After release, scanning restarts at idx 0 with cnt 0 and a zero snapshot.
- dp is constant 1 in all states.

Test Plan (all scenarios use REFRESH_DIV=4):
1. Assert reset for 3 cycles -> an=1111, seg=1111111, dp=1 while reset is high. The first edge after release gives an=1110, seg=1000000.
2. a=2, b=3, sum=5, hold=0, run 2 frames (32 cycles) -> the second frame shows an=1110/seg=0010010, then 1101/0111111, then 1011/0110000, then 0111/0100100, each for exactly 4 cycles.
3. Change a 1->3 while idx=1 -> digit 3 still shows 1 (1111001) this frame; 3 (0110000) appears only from the next frame.
4. hold=1, then change to a=0, b=0, sum=0 for 3 frames -> the display keeps its old values. Drop hold mid-frame -> the new values appear starting at the next idx 0.
5. sum=7 -> digit 0 shows seg=1111000.
6. Assert reset while idx=2 and cnt=2 -> an=1111 in the same cycle, with no waiting for clk. After release the scan restarts at idx 0 with snapshot 0 (seg=1000000).
